// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and helpers for the IF/DM unified-memory arbiter.
// State and owner encodings, parameter defaults, and the streak saturating increment.
package dmem_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    localparam int LAT_DEF           = 2;
    localparam int MAX_DM_STREAK_DEF = 3;

    // Both LAT and MAX_DM_STREAK are limited to 1..7, so three bits suffice
    localparam int CNT_W    = 3;
    localparam int STREAK_W = 3;

    function automatic logic [STREAK_W-1:0] sat_inc(input logic [STREAK_W-1:0] v,
                                                    input logic [STREAK_W-1:0] lim);
        logic [STREAK_W-1:0] r;
        if (v >= lim) begin
            r = lim;
        end else begin
            r = v + 3'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational grant policy: DM has priority, but IF is forced ahead once
// DM has won MAX_DM_STREAK consecutive grants while IF was waiting.
module dmem_arb_pick
    import dmem_arbiter_pkg::*;
#(
    parameter int MAX_DM_STREAK = MAX_DM_STREAK_DEF
) (
    input  logic                if_req,
    input  logic                dm_req,
    input  logic [STREAK_W-1:0] dm_streak,
    output logic                grant_if,
    output logic                grant_dm,
    output logic [STREAK_W-1:0] streak_nxt
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

    // Winner selection and the streak value to commit on this grant
    always_comb begin
        grant_if   = 1'b0;
        grant_dm   = 1'b0;
        streak_nxt = dm_streak;
        if (dm_req && !(if_req && (dm_streak == STREAK_MAX))) begin
            grant_dm = 1'b1;
            if (if_req) begin
                streak_nxt = sat_inc(dm_streak, STREAK_MAX);
            end else begin
                streak_nxt = 3'd0;
            end
        end else if (if_req) begin
            grant_if   = 1'b1;
            streak_nxt = 3'd0;
        end else begin
            streak_nxt = dm_streak;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (fetch / data) arbiter for one fixed-latency single-port memory.
// Sequence per access: IDLE (arbitrate) -> BUSY for LAT cycles -> RESP (done pulse).
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int LAT           = LAT_DEF,
    parameter int MAX_DM_STREAK = MAX_DM_STREAK_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_done,
    output logic        if_stall,
    input  logic        dm_req,
    input  logic        dm_wr,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    output logic [15:0] dm_rdata,
    output logic        dm_done,
    output logic        dm_stall,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    logic [1:0]          state_r;
    logic [1:0]          state_nxt_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [STREAK_W-1:0] dm_streak_r;
    logic                owner_r;

    logic                mem_en_r, mem_wr_r;
    logic [15:0]         mem_addr_r, mem_wdata_r;
    logic                if_done_r, dm_done_r;
    logic [15:0]         if_rdata_r, dm_rdata_r;

    logic                mem_en_nxt_s, mem_wr_nxt_s;
    logic [15:0]         mem_addr_nxt_s, mem_wdata_nxt_s;
    logic                if_done_nxt_s, dm_done_nxt_s;
    logic                cap_if_s, cap_dm_s;

    logic                grant_if_s, grant_dm_s;
    logic [STREAK_W-1:0] streak_nxt_s;
    logic                grant_any_s;

    dmem_arb_pick #(
        .MAX_DM_STREAK(MAX_DM_STREAK)
    ) u_pick (
        .if_req    (if_req),
        .dm_req    (dm_req),
        .dm_streak (dm_streak_r),
        .grant_if  (grant_if_s),
        .grant_dm  (grant_dm_s),
        .streak_nxt(streak_nxt_s)
    );

    assign grant_any_s = grant_if_s | grant_dm_s;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_any_s) begin
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_r == 3'd0) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_RESP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered memory/done outputs and rdata capture strobes
    always_comb begin
        mem_en_nxt_s    = 1'b0;
        mem_wr_nxt_s    = 1'b0;
        mem_addr_nxt_s  = 16'h0000;
        mem_wdata_nxt_s = 16'h0000;
        if_done_nxt_s   = 1'b0;
        dm_done_nxt_s   = 1'b0;
        cap_if_s        = 1'b0;
        cap_dm_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (grant_dm_s) begin
                    mem_en_nxt_s    = 1'b1;
                    mem_wr_nxt_s    = dm_wr;
                    mem_addr_nxt_s  = dm_addr;
                    mem_wdata_nxt_s = dm_wdata;
                end else if (grant_if_s) begin
                    // Fetches are always reads, whatever dm_wr happens to be
                    mem_en_nxt_s    = 1'b1;
                    mem_wr_nxt_s    = 1'b0;
                    mem_addr_nxt_s  = if_addr;
                    mem_wdata_nxt_s = 16'h0000;
                end else begin
                    mem_en_nxt_s    = 1'b0;
                end
            end
            ST_BUSY: begin
                if (cnt_r != 3'd0) begin
                    mem_en_nxt_s    = mem_en_r;
                    mem_wr_nxt_s    = mem_wr_r;
                    mem_addr_nxt_s  = mem_addr_r;
                    mem_wdata_nxt_s = mem_wdata_r;
                end else begin
                    if_done_nxt_s = (owner_r == OWN_IF);
                    dm_done_nxt_s = (owner_r == OWN_DM);
                    cap_if_s      = (owner_r == OWN_IF) & ~mem_wr_r;
                    cap_dm_s      = (owner_r == OWN_DM) & ~mem_wr_r;
                end
            end
            ST_RESP: begin
                mem_en_nxt_s = 1'b0;
            end
            default: begin
                mem_en_nxt_s = 1'b0;
            end
        endcase
    end

    // Datapath registers: outputs, read data, access counter, owner and DM streak
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_en_r    <= 1'b0;
            mem_wr_r    <= 1'b0;
            mem_addr_r  <= 16'h0000;
            mem_wdata_r <= 16'h0000;
            if_done_r   <= 1'b0;
            dm_done_r   <= 1'b0;
            if_rdata_r  <= 16'h0000;
            dm_rdata_r  <= 16'h0000;
            cnt_r       <= 3'd0;
            dm_streak_r <= 3'd0;
            owner_r     <= OWN_IF;
        end else begin
            mem_en_r    <= mem_en_nxt_s;
            mem_wr_r    <= mem_wr_nxt_s;
            mem_addr_r  <= mem_addr_nxt_s;
            mem_wdata_r <= mem_wdata_nxt_s;
            if_done_r   <= if_done_nxt_s;
            dm_done_r   <= dm_done_nxt_s;
            if (cap_if_s) begin
                if_rdata_r <= mem_rdata;
            end
            if (cap_dm_s) begin
                dm_rdata_r <= mem_rdata;
            end
            if ((state_r == ST_IDLE) && grant_any_s) begin
                owner_r     <= grant_dm_s ? OWN_DM : OWN_IF;
                cnt_r       <= CNT_W'(LAT - 1);
                dm_streak_r <= streak_nxt_s;
            end else if ((state_r == ST_BUSY) && (cnt_r != 3'd0)) begin
                cnt_r <= cnt_r - 3'd1;
            end
        end
    end

    assign mem_en    = mem_en_r;
    assign mem_wr    = mem_wr_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign if_done   = if_done_r;
    assign dm_done   = dm_done_r;
    assign if_rdata  = if_rdata_r;
    assign dm_rdata  = dm_rdata_r;
    assign if_stall  = if_req & ~if_done_r;
    assign dm_stall  = dm_req & ~dm_done_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter (LAT=2, MAX_DM_STREAK=3) with a behavioural memory.
// Requests push their expected read data; a monitor pops and compares on each done pulse.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } req_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = 16'h0000;
    logic [15:0] if_rdata;
    logic        if_done, if_stall;
    logic        dm_req = 1'b0;
    logic        dm_wr = 1'b0;
    logic [15:0] dm_addr = 16'h0000;
    logic [15:0] dm_wdata = 16'h0000;
    logic [15:0] dm_rdata;
    logic        dm_done, dm_stall;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = 16'h0000;

    int total = 0;
    int bad   = 0;

    req_t        dm_list[$];
    req_t        if_list[$];
    logic [15:0] exp_dm_q[$];
    logic [15:0] exp_if_q[$];
    int          done_port_q[$];
    int          done_streak_q[$];
    logic [15:0] mem_w[int];

    logic        s_mem_en, s_mem_wr, s_dm_stall, s_if_done, s_dm_done, saw_wr;
    logic [15:0] s_mem_addr, s_mem_wdata;

    always #5 clk = ~clk;

    dmem_arbiter #(.LAT(2), .MAX_DM_STREAK(3)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
        .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Memory model: unwritten words read as {addr[7:0], ~addr[7:0]}
    always @(negedge clk) begin
        if (mem_en && mem_wr) mem_w[int'(mem_addr)] = mem_wdata;
        mem_rdata = mem_w.exists(int'(mem_addr)) ? mem_w[int'(mem_addr)]
                                                 : {mem_addr[7:0], ~mem_addr[7:0]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: compares returned data against the scoreboard on every done pulse
    always @(negedge clk) begin
        if (if_done === 1'b1 && dm_done === 1'b1) begin
            total++; bad++;
            $display("FAIL both_done: got if_done=1 dm_done=1 want at most one");
        end
        if (dm_done === 1'b1) begin
            done_port_q.push_back(1);
            done_streak_q.push_back(int'(dut.dm_streak_r));
            if (exp_dm_q.size() == 0) begin
                total++; bad++;
                $display("FAIL dm_done_unexpected: got pulse want none");
            end else begin
                check("dm_rdata", dm_rdata, exp_dm_q.pop_front());
            end
        end
        if (if_done === 1'b1) begin
            done_port_q.push_back(0);
            done_streak_q.push_back(int'(dut.dm_streak_r));
            if (exp_if_q.size() == 0) begin
                total++; bad++;
                $display("FAIL if_done_unexpected: got pulse want none");
            end else begin
                check("if_rdata", if_rdata, exp_if_q.pop_front());
            end
        end
    end

    task automatic load_dm();
        if (dm_list.size() != 0) begin
            dm_req   = 1'b1;
            dm_wr    = dm_list[0].wr;
            dm_addr  = dm_list[0].addr;
            dm_wdata = dm_list[0].wdata;
            exp_dm_q.push_back(dm_list[0].exp);
        end else begin
            dm_req = 1'b0;
        end
    endtask

    task automatic load_if();
        if (if_list.size() != 0) begin
            if_req  = 1'b1;
            if_addr = if_list[0].addr;
            exp_if_q.push_back(if_list[0].exp);
        end else begin
            if_req = 1'b0;
        end
    endtask

    // One cycle: sample at the falling edge, then let the requesters advance on done
    task automatic tick();
        @(negedge clk);
        s_mem_en    = mem_en;
        s_mem_wr    = mem_wr;
        s_mem_addr  = mem_addr;
        s_mem_wdata = mem_wdata;
        s_dm_stall  = dm_stall;
        s_if_done   = if_done;
        s_dm_done   = dm_done;
        if (mem_wr === 1'b1) saw_wr = 1'b1;
        if (dm_done === 1'b1 && dm_list.size() != 0) begin
            dm_list.delete(0);
            load_dm();
        end
        if (if_done === 1'b1 && if_list.size() != 0) begin
            if_list.delete(0);
            load_if();
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((dm_list.size() != 0 || if_list.size() != 0) && n < 60) begin
            tick();
            n++;
        end
        check({name, "_complete"}, 32'(dm_list.size() + if_list.size()), 32'd0);
        tick();
        tick();
    endtask

    initial begin
        int exp_port[5];
        int exp_streak[5];
        exp_port   = '{1, 1, 1, 0, 1};
        exp_streak = '{1, 2, 3, 0, 0};
        saw_wr = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_mem_en", mem_en, 32'd0);
        check("rst_mem_wr", mem_wr, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_dones", {if_done, dm_done}, 32'd0);
        check("rst_rdata", {if_rdata, dm_rdata}, 32'd0);
        check("rst_state", dut.state_r, 32'(ST_IDLE));
        rst = 1'b1;
        tick();

        // DM write of 0xBEEF to 0x0010, then read it back
        dm_list.push_back(req_t'{1'b1, 16'h0010, 16'hBEEF, 16'h0000});
        dm_list.push_back(req_t'{1'b0, 16'h0010, 16'h0000, 16'hBEEF});
        load_dm();
        #1;
        check("t1_stall_c0", dm_stall, 32'd1);
        check("t1_en_c0", mem_en, 32'd0);
        for (int c = 1; c <= 2; c++) begin
            tick();
            check("t1_en", s_mem_en, 32'd1);
            check("t1_wr", s_mem_wr, 32'd1);
            check("t1_addr", s_mem_addr, 32'h0010);
            check("t1_wdata", s_mem_wdata, 32'hBEEF);
            check("t1_stall", s_dm_stall, 32'd1);
        end
        tick();
        check("t1_done_c3", s_dm_done, 32'd1);
        check("t1_en_c3", s_mem_en, 32'd0);
        check("t1_stall_c3", s_dm_stall, 32'd0);
        drain("t1");

        // Simultaneous IF and DM: DM first, IF granted in cycle 4
        dm_list.push_back(req_t'{1'b0, 16'h0040, 16'h0000, 16'h40BF});
        if_list.push_back(req_t'{1'b0, 16'h0080, 16'h0000, 16'h807F});
        load_dm();
        load_if();
        tick(); tick(); tick();
        check("t2_dm_done_c3", s_dm_done, 32'd1);
        check("t2_if_done_c3", s_if_done, 32'd0);
        tick();
        check("t2_en_c4", s_mem_en, 32'd0);
        for (int c = 5; c <= 6; c++) begin
            tick();
            check("t2_if_en", s_mem_en, 32'd1);
            check("t2_if_addr", s_mem_addr, 32'h0080);
        end
        tick();
        check("t2_if_done_c7", s_if_done, 32'd1);
        drain("t2");

        // Starvation guard: IF held while DM issues four reads
        done_port_q.delete();
        done_streak_q.delete();
        dm_list.push_back(req_t'{1'b0, 16'h0001, 16'h0000, 16'h01FE});
        dm_list.push_back(req_t'{1'b0, 16'h0002, 16'h0000, 16'h02FD});
        dm_list.push_back(req_t'{1'b0, 16'h0003, 16'h0000, 16'h03FC});
        dm_list.push_back(req_t'{1'b0, 16'h0004, 16'h0000, 16'h04FB});
        if_list.push_back(req_t'{1'b0, 16'h0081, 16'h0000, 16'h817E});
        load_dm();
        load_if();
        drain("t3");
        check("t3_grants", 32'(done_port_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < done_port_q.size()) begin
                check("t3_order", 32'(done_port_q[i]), 32'(exp_port[i]));
                check("t3_streak", 32'(done_streak_q[i]), 32'(exp_streak[i]));
            end
        end

        // IF fetch with dm_wr left high: must stay a read
        dm_wr   = 1'b1;
        dm_addr = 16'h0033;
        saw_wr  = 1'b0;
        if_list.push_back(req_t'{1'b0, 16'h0010, 16'h0000, 16'hBEEF});
        load_if();
        drain("t4");
        check("t4_no_write", saw_wr, 32'd0);

        // Reset during the second access cycle of a DM read
        dm_wr   = 1'b0;
        dm_addr = 16'h0020;
        dm_req  = 1'b1;
        tick();
        tick();
        check("t5_en_c2", s_mem_en, 32'd1);
        rst    = 1'b0;
        dm_req = 1'b0;
        tick();
        check("t5_en_after_rst", s_mem_en, 32'd0);
        check("t5_done_after_rst", s_dm_done, 32'd0);
        check("t5_rdata", {if_rdata, dm_rdata}, 32'd0);
        check("t5_state", dut.state_r, 32'(ST_IDLE));
        rst = 1'b1;
        tick();
        tick();
        check("t5_en_idle", s_mem_en, 32'd0);
        dm_list.push_back(req_t'{1'b0, 16'h0020, 16'h0000, 16'h20DF});
        load_dm();
        drain("t5");

        // Address change while busy has no effect on the access
        dm_list.push_back(req_t'{1'b0, 16'h0010, 16'h0000, 16'hBEEF});
        load_dm();
        tick();
        check("t6_addr_c1", s_mem_addr, 32'h0010);
        dm_addr = 16'h0020;
        tick();
        check("t6_addr_c2", s_mem_addr, 32'h0010);
        drain("t6");

        check("scoreboard_empty", 32'(exp_dm_q.size() + exp_if_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
